spi_master_seq: RTL and testbench

// - Host-side SPI master and transaction sequencer for the SPI slave memory block (7b address, 1b RW, 8b data).
// - Accepts one read/write request per handshake and drives cs/sclk/mosi for one 16-bit frame.
// - Captures miso during the data phase and returns rdata with a one-cycle done pulse.
// - After an abort, issues a flush sclk pulse with cs high so the slave FSM returns to its start state.

---
 rtl/spi_master_seq_pkg.sv | 28 ++
 rtl/spi_master_seq_clk_div.sv | 28 ++
 rtl/spi_master_seq.sv | 191 +++++++++++++++++++
 tb/tb_spi_master_seq.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_seq_pkg.sv
// Shared definitions for the SPI master sequencer: frame layout, FSM encoding
// and the frame builder used when a request is accepted.
package spi_master_seq_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int RW_BIT     = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_END   = 3'd4,
    ST_FLUSH = 3'd5
  } state_e;

  // Reads carry an all-zero data phase so the slave sees no stray write data.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [ADDR_W-1:0] addr,
    input logic              rw,
    input logic [DATA_W-1:0] wdata
  );
    build_frame = {addr, rw, (rw ? {DATA_W{1'b0}} : wdata)};
  endfunction

endpackage

// File: rtl/spi_master_seq_clk_div.sv
// Half-period tick generator for sclk: counts CLK_DIV clk cycles while enabled
// and restarts from zero whenever the enable drops.
module spi_master_seq_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic tick_o
);

  localparam int DW = $clog2(CLK_DIV + 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;

  assign tick_o = en_i && (div_cnt_q == DW'(CLK_DIV - 1));

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    if (!en_i || tick_o) div_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_cnt_q <= '0;
    else        div_cnt_q <= div_cnt_d;
  end

endmodule

// File: rtl/spi_master_seq.sv
// SPI mode-0 master that sequences one 16-bit {addr, rw, data} frame per request
// and issues a cs-high flush pulse after an abort. All outputs are registered.
module spi_master_seq
  import spi_master_seq_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 1,
  parameter int CS_HOLD  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic              rw_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              abort_i,
  input  logic              miso_i,
  output logic              ready_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              cs_o,
  output logic              sclk_o,
  output logic              mosi_o,
  output logic [2:0]        state_o
);

  localparam int PH_MAX = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > 3) ? CS_SETUP : 3)
                                               : ((CS_HOLD > 3) ? CS_HOLD : 3);
  localparam int PH_W   = $clog2(PH_MAX + 1);

  // Handshake: a request transfers on any cycle where req_i && ready_o; ready_o
  // is high only in IDLE and END, and the request fields are latched that cycle.
  state_e                  state_q, state_d;
  logic [PH_W-1:0]         ph_q, ph_d;
  logic [3:0]              bit_q, bit_d;
  logic [FRAME_BITS-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]       rx_q, rx_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    rw_q, rw_d;
  logic                    cs_q, cs_d;
  logic                    sclk_q, sclk_d;
  logic                    done_q, done_d;
  logic                    ready_q, ready_d;
  logic                    tick;
  logic                    div_en;
  logic                    abort_hit;

  assign abort_hit = abort_i && (state_q == ST_SETUP || state_q == ST_SHIFT ||
                                 state_q == ST_HOLD);
  assign div_en    = (state_q == ST_SHIFT && !abort_i) || state_q == ST_FLUSH;

  spi_master_seq_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (div_en),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    rw_d    = rw_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    done_d  = 1'b0;
    ready_d = ready_q;

    unique case (state_q)
      // END accepts like IDLE so a held req leaves cs high for only one cycle.
      ST_IDLE, ST_END: begin
        state_d = ST_IDLE;
        cs_d    = 1'b1;
        ready_d = 1'b1;
        if (req_i && ready_q) begin
          state_d = ST_SETUP;
          tx_d    = build_frame(addr_i, rw_i, wdata_i);
          rw_d    = rw_i;
          cs_d    = 1'b0;
          sclk_d  = 1'b0;
          ready_d = 1'b0;
          ph_d    = '0;
          bit_d   = '0;
        end
      end
      ST_SETUP: begin
        if (ph_q == PH_W'(CS_SETUP - 1)) begin
          state_d = ST_SHIFT;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
            if (bit_q[3]) rx_d = {rx_q[DATA_W-2:0], miso_i};
          end else begin
            sclk_d = 1'b0;
            tx_d   = {tx_q[FRAME_BITS-2:0], 1'b0};
            if (bit_q == 4'd15) begin
              state_d = ST_HOLD;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end
      end
      ST_HOLD: begin
        if (ph_q == PH_W'(CS_HOLD - 1)) begin
          state_d = ST_END;
          ph_d    = '0;
          cs_d    = 1'b1;
          done_d  = 1'b1;
          ready_d = 1'b1;
          if (rw_q) rdata_d = rx_q;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      // Three CLK_DIV phases with cs high: idle low, sclk high, sclk low.
      ST_FLUSH: begin
        if (tick) begin
          if (ph_q == PH_W'(2)) begin
            state_d = ST_IDLE;
            ph_d    = '0;
            sclk_d  = 1'b0;
            ready_d = 1'b1;
          end else begin
            ph_d   = ph_q + 1'b1;
            sclk_d = (ph_q == '0);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort_hit) begin
      state_d = ST_FLUSH;
      cs_d    = 1'b1;
      sclk_d  = 1'b0;
      tx_d    = '0;
      ph_d    = '0;
      bit_d   = '0;
      done_d  = 1'b0;
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ph_q    <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      rw_q    <= 1'b0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      rw_q    <= rw_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign ready_o = ready_q;
  assign done_o  = done_q;
  assign rdata_o = rdata_q;
  assign cs_o    = cs_q;
  assign sclk_o  = sclk_q;
  assign mosi_o  = tx_q[FRAME_BITS-1];
  assign state_o = state_q;

endmodule

// File: tb/tb_spi_master_seq.sv
// Directed bench for spi_master_seq: write/read frames against a small slave
// model, back-to-back, abort/flush, async reset, and CLK_DIV/CS_SETUP variants.
module tb_spi_master_seq;

  localparam int D = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       req = 1'b0, rw = 1'b0, abort = 1'b0, miso = 1'b0;
  logic       req_b = 1'b0, req_c = 1'b0, tie0 = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;

  logic       ready, done, cs, sclk, mosi;
  logic [7:0] rdata;
  logic [2:0] state;
  logic       ready_b, done_b, cs_b, sclk_b, mosi_b;
  logic [7:0] rdata_b;
  logic [2:0] state_b;
  logic       ready_c, done_c, cs_c, sclk_c, mosi_c;
  logic [7:0] rdata_c;
  logic [2:0] state_c;

  spi_master_seq dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .rw_i(rw), .addr_i(addr), .wdata_i(wdata),
    .abort_i(abort), .miso_i(miso), .ready_o(ready), .done_o(done), .rdata_o(rdata),
    .cs_o(cs), .sclk_o(sclk), .mosi_o(mosi), .state_o(state)
  );

  spi_master_seq #(.CLK_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_i(req_b), .rw_i(rw), .addr_i(addr), .wdata_i(wdata),
    .abort_i(tie0), .miso_i(tie0), .ready_o(ready_b), .done_o(done_b), .rdata_o(rdata_b),
    .cs_o(cs_b), .sclk_o(sclk_b), .mosi_o(mosi_b), .state_o(state_b)
  );

  spi_master_seq #(.CLK_DIV(5), .CS_SETUP(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .req_i(req_c), .rw_i(rw), .addr_i(addr), .wdata_i(wdata),
    .abort_i(tie0), .miso_i(tie0), .ready_o(ready_c), .done_o(done_c), .rdata_o(rdata_c),
    .cs_o(cs_c), .sclk_o(sclk_c), .mosi_o(mosi_c), .state_o(state_c)
  );

  // scoreboard
  logic [15:0] exp_frame_q[$];
  logic [7:0]  exp_rdata_q[$];
  logic [7:0]  slave_data  = 8'h00;
  logic [7:0]  model_rdata = 8'h00;
  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // monitor + slave model, sampled on the falling clk edge
  int          rise_cnt = 0, flush_rises = 0, done_cnt = 0;
  logic        prev_sclk = 1'b0, prev_cs = 1'b1;
  logic [15:0] frame_sh = '0;
  logic [15:0] ef;
  logic [7:0]  er;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      rise_cnt = 0; prev_sclk = 1'b0; prev_cs = 1'b1; miso = 1'b0;
    end else begin
      if (prev_cs && !cs) begin rise_cnt = 0; frame_sh = '0; end
      if (sclk && !prev_sclk) begin
        if (!cs) begin frame_sh = {frame_sh[14:0], mosi}; rise_cnt++; end
        else flush_rises++;
      end
      if (!sclk && prev_sclk && !cs && rise_cnt >= 8 && rise_cnt < 16)
        miso = slave_data[15 - rise_cnt];
      if (done) begin
        done_cnt++;
        if (exp_frame_q.size() == 0) begin
          chk("spurious_done", 32'(exp_frame_q.size()), 32'd1);
        end else begin
          ef = exp_frame_q.pop_front();
          er = exp_rdata_q.pop_front();
          chk("frame_bits", 32'(frame_sh), 32'(ef));
          chk("rise_count", 32'(rise_cnt), 32'd16);
          chk("rdata_at_done", 32'(rdata), 32'(er));
        end
      end
      prev_sclk = sclk; prev_cs = cs;
    end
  end

  // driver tasks
  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic do_req(input logic [6:0] a, input logic r, input logic [7:0] w,
                        input bit push, output int c0);
    int k;
    k = 0;
    while (!ready && k < 200) begin tick(); k++; end
    chk("ready_before_req", 32'(ready), 32'd1);
    req = 1'b1; addr = a; rw = r; wdata = w; c0 = cyc;
    if (push) begin
      exp_frame_q.push_back({a, r, (r ? 8'h00 : w)});
      exp_rdata_q.push_back(r ? slave_data : model_rdata);
      if (r) model_rdata = slave_data;
    end
    tick();
    req = 1'b0;
    chk("ready_drop", 32'(ready), 32'd0);
    chk("cs_low_setup", 32'(cs), 32'd0);
  endtask

  task automatic wait_done(input int c0, input int lat, input string tag);
    int k;
    k = 0;
    while (!done && k < 400) begin tick(); k++; end
    chk(tag, 32'(cyc - c0), 32'(lat));
  endtask

  task automatic wait_rises(input int n);
    int k;
    k = 0;
    while (rise_cnt < n && k < 400) begin tick(); k++; end
    chk("rise_reach", 32'(rise_cnt), 32'(n));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c0, c1, dc, fr0;
    int lat_exp, dd, csu, hi, lo, rs, k;
    logic ps, sc, ss, sd;

    // reset state
    repeat (3) tick();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_cs",    32'(cs),    32'd1);
    chk("rst_sclk_mosi", 32'({sclk, mosi}), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    rst_n = 1'b1;
    tick();

    // write with the reference pattern
    do_req(7'h2A, 1'b0, 8'hC3, 1'b1, c0);
    wait_done(c0, 3 + 32 * D, "lat_write");
    chk("write_frame_literal", 32'(frame_sh), 32'h54C3);

    // read: slave returns 5E, data phase must be zero
    slave_data = 8'h5E;
    do_req(7'h01, 1'b1, 8'hFF, 1'b1, c0);
    wait_done(c0, 3 + 32 * D, "lat_read");
    chk("read_rdata", 32'(rdata), 32'h5E);
    tick();
    chk("done_pulse_width", 32'(done), 32'd0);
    chk("rdata_held", 32'(rdata), 32'h5E);

    // back-to-back: req held across END
    slave_data = 8'hA7;
    do_req(7'h55, 1'b0, 8'h3C, 1'b1, c0);
    wait_done(c0, 3 + 32 * D, "lat_b2b1");
    chk("b2b_end_cs", 32'(cs), 32'd1);
    req = 1'b1; addr = 7'h12; rw = 1'b1; wdata = 8'h00; c1 = cyc;
    exp_frame_q.push_back({7'h12, 1'b1, 8'h00});
    exp_rdata_q.push_back(slave_data);
    model_rdata = slave_data;
    tick();
    req = 1'b0;
    chk("b2b_cs_gap", 32'(cs), 32'd0);
    chk("b2b_ready", 32'(ready), 32'd0);
    wait_done(c1, 3 + 32 * D, "lat_b2b2");

    // abort after the 5th rise
    dc = done_cnt; fr0 = flush_rises;
    do_req(7'h33, 1'b0, 8'h99, 1'b0, c0);
    wait_rises(5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_cs", 32'(cs), 32'd1);
    chk("abort_sclk", 32'(sclk), 32'd0);
    repeat (3 * D + 2) tick();
    chk("flush_pulses", 32'(flush_rises - fr0), 32'd1);
    chk("abort_rises", 32'(rise_cnt), 32'd5);
    chk("abort_no_done", 32'(done_cnt), 32'(dc));
    chk("abort_ready", 32'(ready), 32'd1);
    do_req(7'h0F, 1'b0, 8'h5A, 1'b1, c0);
    wait_done(c0, 3 + 32 * D, "lat_after_abort");

    // req while busy is dropped
    do_req(7'h44, 1'b0, 8'h81, 1'b1, c0);
    wait_rises(3);
    addr = 7'h7F; req = 1'b1;
    tick();
    req = 1'b0;
    wait_done(c0, 3 + 32 * D, "lat_busy");
    dc = done_cnt;
    repeat (80) tick();
    chk("busy_no_extra", 32'(done_cnt), 32'(dc));
    chk("busy_idle_cs", 32'(cs), 32'd1);

    // async reset mid-SHIFT
    do_req(7'h20, 1'b0, 8'h11, 1'b0, c0);
    wait_rises(4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cs", 32'(cs), 32'd1);
    chk("arst_sclk_mosi", 32'({sclk, mosi}), 32'd0);
    chk("arst_ready_done", 32'({ready, done}), 32'b10);
    chk("arst_rdata", 32'(rdata), 32'd0);
    model_rdata = 8'h00;
    tick();
    rst_n = 1'b1;
    fr0 = flush_rises;
    repeat (10) tick();
    chk("arst_no_flush", 32'(flush_rises - fr0), 32'd0);
    chk("arst_ready_after", 32'(ready), 32'd1);

    // parameter variants: CLK_DIV=1 and CLK_DIV=5/CS_SETUP=3
    for (int s = 0; s < 2; s++) begin
      dd  = (s == 0) ? 1 : 5;
      csu = (s == 0) ? 1 : 3;
      lat_exp = 1 + csu + 32 * dd + 1;
      hi = 0; lo = 0; rs = 0; k = 0; ps = 1'b0;
      addr = 7'h2A; rw = 1'b0; wdata = 8'hC3;
      if (s == 0) req_b = 1'b1; else req_c = 1'b1;
      c0 = cyc;
      tick();
      req_b = 1'b0; req_c = 1'b0;
      while (k < 400) begin
        sc = (s == 0) ? cs_b   : cs_c;
        ss = (s == 0) ? sclk_b : sclk_c;
        sd = (s == 0) ? done_b : done_c;
        if (sd) break;
        if (!sc) begin
          if (ss) hi++; else lo++;
          if (ss && !ps) rs++;
        end
        ps = ss;
        tick();
        k++;
      end
      chk("sweep_latency", 32'(cyc - c0), 32'(lat_exp));
      chk("sweep_sclk_high", 32'(hi), 32'(16 * dd));
      chk("sweep_sclk_low", 32'(lo), 32'(16 * dd + csu + 1));
      chk("sweep_rises", 32'(rs), 32'd16);
    end

    repeat (2) tick();
    chk("queue_drained", 32'(exp_frame_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
